// File: rtl/mem_violation_detect_n_if.sv
// Store->load violation detector bus.
// master: LSU side; drives the store/load/lq candidates, flush and redir_ready.
// slave:  detector side; drives the redirect request redir_valid/redir_robIdx/redir_fsq.
// Multi-lane fields are packed flat, lane n at [n*W +: W].
interface mem_violation_detect_n_if #(
  parameter int unsigned STORE_PIPELINE = 2,
  parameter int unsigned LOAD_PIPELINE  = 2,
  parameter int unsigned LQ_WIDTH       = 5,
  parameter int unsigned ROB_WIDTH      = 6,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned FSQ_WIDTH      = 8
);
  logic [STORE_PIPELINE-1:0]              st_en;
  logic [STORE_PIPELINE*ADDR_WIDTH-1:0]   st_addr;
  logic [STORE_PIPELINE*4-1:0]            st_mask;
  logic [STORE_PIPELINE*(LQ_WIDTH+1)-1:0] st_lqIdx;

  logic [LOAD_PIPELINE-1:0]               s1_en, s2_en;
  logic [LOAD_PIPELINE*ADDR_WIDTH-1:0]    s1_addr, s2_addr;
  logic [LOAD_PIPELINE*4-1:0]             s1_mask, s2_mask;
  logic [LOAD_PIPELINE*(LQ_WIDTH+1)-1:0]  s1_lqIdx, s2_lqIdx;
  logic [LOAD_PIPELINE*(ROB_WIDTH+1)-1:0] s1_robIdx, s2_robIdx;
  logic [LOAD_PIPELINE*FSQ_WIDTH-1:0]     s1_fsq, s2_fsq;

  logic                                   lq_en;
  logic [LQ_WIDTH:0]                      lq_lqIdx;
  logic [ROB_WIDTH:0]                     lq_robIdx;
  logic [FSQ_WIDTH-1:0]                   lq_fsq;

  logic                                   flush;
  logic                                   redir_valid;
  logic                                   redir_ready;
  logic [ROB_WIDTH:0]                     redir_robIdx;
  logic [FSQ_WIDTH-1:0]                   redir_fsq;

  modport master (
    output st_en, st_addr, st_mask, st_lqIdx,
    output s1_en, s1_addr, s1_mask, s1_lqIdx, s1_robIdx, s1_fsq,
    output s2_en, s2_addr, s2_mask, s2_lqIdx, s2_robIdx, s2_fsq,
    output lq_en, lq_lqIdx, lq_robIdx, lq_fsq,
    output flush, redir_ready,
    input  redir_valid, redir_robIdx, redir_fsq
  );

  modport slave (
    input  st_en, st_addr, st_mask, st_lqIdx,
    input  s1_en, s1_addr, s1_mask, s1_lqIdx, s1_robIdx, s1_fsq,
    input  s2_en, s2_addr, s2_mask, s2_lqIdx, s2_robIdx, s2_fsq,
    input  lq_en, lq_lqIdx, lq_robIdx, lq_fsq,
    input  flush, redir_ready,
    output redir_valid, redir_robIdx, redir_fsq
  );
endinterface

// File: rtl/mem_violation_detect_n.sv
// Store->load memory-ordering violation detector.
// Each store write is matched against every load in s1/s2; the oldest violating load
// (by lqIdx) is reduced per store (R1), then across stores (R2), then merged with the
// load-queue report and held in a pending redirect register with valid/ready handshake.
// Ports: clk, rst (async, active low), bus (mem_violation_detect_n_if.slave).
module mem_violation_detect_n #(
  parameter int unsigned STORE_PIPELINE = 2,
  parameter int unsigned LOAD_PIPELINE  = 2,
  parameter int unsigned LQ_WIDTH       = 5,
  parameter int unsigned ROB_WIDTH      = 6,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned FSQ_WIDTH      = 8
) (
  input logic                    clk,
  input logic                    rst,
  mem_violation_detect_n_if.slave bus
);
  localparam int unsigned LqW     = LQ_WIDTH + 1;
  localparam int unsigned RobW    = ROB_WIDTH + 1;
  localparam int unsigned NumCand = 2 * LOAD_PIPELINE;

  typedef struct packed {
    logic                 valid;
    logic [LQ_WIDTH:0]    lq;
    logic [ROB_WIDTH:0]   rob;
    logic [FSQ_WIDTH-1:0] fsq;
  } viol_t;

  // {dir, idx} age compare; a differing dir bit means the index has wrapped.
  function automatic logic older(input logic [LQ_WIDTH:0] a, input logic [LQ_WIDTH:0] b);
    if (a[LQ_WIDTH] == b[LQ_WIDTH]) return a[LQ_WIDTH-1:0] < b[LQ_WIDTH-1:0];
    else                            return a[LQ_WIDTH-1:0] > b[LQ_WIDTH-1:0];
  endfunction

  viol_t                 cand      [NumCand];
  logic [ADDR_WIDTH-1:0] cand_addr [NumCand];
  logic [3:0]            cand_mask [NumCand];
  logic [NumCand-1:0]    hit       [STORE_PIPELINE];
  viol_t                 r1_d      [STORE_PIPELINE];
  viol_t                 r1_q      [STORE_PIPELINE];
  viol_t                 r2_d, r2_q;
  viol_t                 c, p_d, p_q;

  // s2 loads occupy the low candidate slots: the scans below keep the earliest entry on
  // an lqIdx tie, which gives s2 priority over s1 and then lower pipeline index.
  always_comb begin
    for (int j = 0; j < LOAD_PIPELINE; j++) begin
      cand[j].valid      = bus.s2_en[j];
      cand[j].lq         = bus.s2_lqIdx[j*LqW +: LqW];
      cand[j].rob        = bus.s2_robIdx[j*RobW +: RobW];
      cand[j].fsq        = bus.s2_fsq[j*FSQ_WIDTH +: FSQ_WIDTH];
      cand_addr[j]       = bus.s2_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
      cand_mask[j]       = bus.s2_mask[j*4 +: 4];
      cand[LOAD_PIPELINE+j].valid = bus.s1_en[j];
      cand[LOAD_PIPELINE+j].lq    = bus.s1_lqIdx[j*LqW +: LqW];
      cand[LOAD_PIPELINE+j].rob   = bus.s1_robIdx[j*RobW +: RobW];
      cand[LOAD_PIPELINE+j].fsq   = bus.s1_fsq[j*FSQ_WIDTH +: FSQ_WIDTH];
      cand_addr[LOAD_PIPELINE+j]  = bus.s1_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
      cand_mask[LOAD_PIPELINE+j]  = bus.s1_mask[j*4 +: 4];
    end
  end

  // A load violates when it overlaps the store's word and is not older than the store's
  // first-younger lqIdx (equal lqIdx is the first younger load itself).
  always_comb begin
    for (int i = 0; i < STORE_PIPELINE; i++) begin
      for (int k = 0; k < NumCand; k++) begin
        hit[i][k] = bus.st_en[i] && cand[k].valid
            && (bus.st_addr[i*ADDR_WIDTH+2 +: ADDR_WIDTH-2] == cand_addr[k][ADDR_WIDTH-1:2])
            && ((bus.st_mask[i*4 +: 4] & cand_mask[k]) != 4'd0)
            && !older(cand[k].lq, bus.st_lqIdx[i*LqW +: LqW]);
      end
    end
  end

  // Stage 1: oldest hit per store.
  always_comb begin
    for (int i = 0; i < STORE_PIPELINE; i++) begin
      r1_d[i] = '0;
      for (int k = 0; k < NumCand; k++) begin
        if (hit[i][k] && (!r1_d[i].valid || older(cand[k].lq, r1_d[i].lq))) begin
          r1_d[i]       = cand[k];
          r1_d[i].valid = 1'b1;
        end
      end
      r1_d[i].valid = r1_d[i].valid & ~bus.flush;
    end
  end

  // Stage 2: oldest across stores, lower store index on a tie.
  always_comb begin
    r2_d = '0;
    for (int i = 0; i < STORE_PIPELINE; i++) begin
      if (r1_q[i].valid && (!r2_d.valid || older(r1_q[i].lq, r2_d.lq))) r2_d = r1_q[i];
    end
    r2_d.valid = r2_d.valid & ~bus.flush;
  end

  // Stage 3: merge with the load-queue report (lq wins a tie) and update the pending slot.
  always_comb begin
    c.valid = bus.lq_en;
    c.lq    = bus.lq_lqIdx;
    c.rob   = bus.lq_robIdx;
    c.fsq   = bus.lq_fsq;
    if (r2_q.valid && (!c.valid || older(r2_q.lq, c.lq))) c = r2_q;

    p_d = p_q;
    if (bus.flush) begin
      p_d.valid = 1'b0;
    end else if (p_q.valid && bus.redir_ready) begin
      if (c.valid) p_d = c;
      else         p_d.valid = 1'b0;
    end else if (p_q.valid) begin
      // Under backpressure only a strictly older violation may replace the payload.
      if (c.valid && older(c.lq, p_q.lq)) p_d = c;
    end else if (c.valid) begin
      p_d = c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STORE_PIPELINE; i++) r1_q[i] <= '0;
      r2_q <= '0;
      p_q  <= '0;
    end else begin
      for (int i = 0; i < STORE_PIPELINE; i++) r1_q[i] <= r1_d[i];
      r2_q <= r2_d;
      p_q  <= p_d;
    end
  end

  assign bus.redir_valid  = p_q.valid;
  assign bus.redir_robIdx = p_q.rob;
  assign bus.redir_fsq    = p_q.fsq;
endmodule

// File: tb/tb_mem_violation_detect_n.sv
// Bench for mem_violation_detect_n: table of single-cycle store/load vectors checked
// through a latency-tagged scoreboard, plus hand sequences for reset, backpressure,
// lq/R2 tie, multi-store reduction and flush.
module tb_mem_violation_detect_n;
  localparam int SP = 2, LP = 2, LQW = 5, ROBW = 6, AW = 32, FW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_violation_detect_n_if #(.STORE_PIPELINE(SP), .LOAD_PIPELINE(LP), .LQ_WIDTH(LQW),
    .ROB_WIDTH(ROBW), .ADDR_WIDTH(AW), .FSQ_WIDTH(FW)) bus ();

  mem_violation_detect_n #(.STORE_PIPELINE(SP), .LOAD_PIPELINE(LP), .LQ_WIDTH(LQW),
    .ROB_WIDTH(ROBW), .ADDR_WIDTH(AW), .FSQ_WIDTH(FW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic          v;
    logic [1:0]    stage;
    logic [3:0]    j;
    logic [AW-1:0] addr;
    logic [3:0]    mask;
    logic [LQW:0]  lq;
    logic [ROBW:0] rob;
    logic [FW-1:0] fsq;
  } load_t;

  typedef struct packed {
    logic          st_v;
    logic [3:0]    st_p;
    logic [AW-1:0] st_addr;
    logic [3:0]    st_mask;
    logic [LQW:0]  st_lq;
    load_t         la;
    load_t         lb;
    logic [1:0]    win;  // 0: no redirect, 1: la wins, 2: lb wins
  } vec_t;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [ROBW:0] rob;
    logic [FW-1:0] fsq;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   mon_en = 1'b0;

  // Every redirect seen must match the front of the scoreboard, including its cycle.
  always @(negedge clk) begin
    if (mon_en && bus.redir_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_redir", 64'(bus.redir_robIdx), 64'hdead);
      end else begin
        mon_e = sb.pop_front();
        chk("redir_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("redir_rob", 64'(bus.redir_robIdx), 64'(mon_e.rob));
        chk("redir_fsq", 64'(bus.redir_fsq), 64'(mon_e.fsq));
      end
    end
  end

  task automatic push_exp(input int lat, input logic [ROBW:0] rob, input logic [FW-1:0] fsq);
    exp_t e;
    e.cyc = 32'(cyc + lat);
    e.rob = rob;
    e.fsq = fsq;
    sb.push_back(e);
  endtask

  task automatic clear_inputs();
    bus.st_en = '0;  bus.st_addr = '0;  bus.st_mask = '0;  bus.st_lqIdx = '0;
    bus.s1_en = '0;  bus.s1_addr = '0;  bus.s1_mask = '0;  bus.s1_lqIdx = '0;
    bus.s1_robIdx = '0;  bus.s1_fsq = '0;
    bus.s2_en = '0;  bus.s2_addr = '0;  bus.s2_mask = '0;  bus.s2_lqIdx = '0;
    bus.s2_robIdx = '0;  bus.s2_fsq = '0;
    bus.lq_en = 1'b0;  bus.lq_lqIdx = '0;  bus.lq_robIdx = '0;  bus.lq_fsq = '0;
    bus.flush = 1'b0;
  endtask

  task automatic put_store(input int p, input logic [AW-1:0] a, input logic [3:0] m,
                           input logic [LQW:0] lq);
    bus.st_en[p] = 1'b1;
    bus.st_addr[p*AW +: AW] = a;
    bus.st_mask[p*4 +: 4] = m;
    bus.st_lqIdx[p*(LQW+1) +: LQW+1] = lq;
  endtask

  task automatic put_load(input load_t l);
    int j;
    j = int'(l.j);
    if (!l.v) return;
    if (l.stage == 2'd2) begin
      bus.s2_en[j] = 1'b1;
      bus.s2_addr[j*AW +: AW] = l.addr;
      bus.s2_mask[j*4 +: 4] = l.mask;
      bus.s2_lqIdx[j*(LQW+1) +: LQW+1] = l.lq;
      bus.s2_robIdx[j*(ROBW+1) +: ROBW+1] = l.rob;
      bus.s2_fsq[j*FW +: FW] = l.fsq;
    end else begin
      bus.s1_en[j] = 1'b1;
      bus.s1_addr[j*AW +: AW] = l.addr;
      bus.s1_mask[j*4 +: 4] = l.mask;
      bus.s1_lqIdx[j*(LQW+1) +: LQW+1] = l.lq;
      bus.s1_robIdx[j*(ROBW+1) +: ROBW+1] = l.rob;
      bus.s1_fsq[j*FW +: FW] = l.fsq;
    end
  endtask

  task automatic put_lq(input logic [LQW:0] lq, input logic [ROBW:0] rob,
                        input logic [FW-1:0] fsq);
    bus.lq_en = 1'b1;
    bus.lq_lqIdx = lq;
    bus.lq_robIdx = rob;
    bus.lq_fsq = fsq;
  endtask

  function automatic load_t ld(input int stage, input int j, input logic [AW-1:0] a,
      input logic [3:0] m, input logic [LQW:0] lq, input logic [ROBW:0] rob,
      input logic [FW-1:0] fsq);
    load_t l;
    l.v = 1'b1;  l.stage = 2'(stage);  l.j = 4'(j);  l.addr = a;  l.mask = m;
    l.lq = lq;  l.rob = rob;  l.fsq = fsq;
    return l;
  endfunction

  function automatic vec_t mk(input logic sv, input int sp, input logic [AW-1:0] sa,
      input logic [3:0] sm, input logic [LQW:0] slq, input load_t la, input load_t lb,
      input int win);
    vec_t v;
    v.st_v = sv;  v.st_p = 4'(sp);  v.st_addr = sa;  v.st_mask = sm;  v.st_lq = slq;
    v.la = la;  v.lb = lb;  v.win = 2'(win);
    return v;
  endfunction

  localparam int NV = 11;
  vec_t  vecs [NV];
  load_t none;

  initial begin
    none = '0;
    // {dir,idx} lqIdx: {1,1} = 33, {1,2} = 34, {1,3} = 35.
    vecs[0]  = mk(1, 0, 32'h1000, 4'hf, 6'd3,
                  ld(1, 1, 32'h1002, 4'b0100, 6'd5, 7'd9, 8'h21), none, 1);
    vecs[1]  = mk(1, 0, 32'h1000, 4'hf, 6'd3,
                  ld(1, 1, 32'h1002, 4'b0100, 6'd2, 7'd9, 8'h21), none, 0);
    vecs[2]  = mk(1, 0, 32'h1000, 4'b0011, 6'd3,
                  ld(1, 1, 32'h1000, 4'b1100, 6'd5, 7'd9, 8'h21), none, 0);
    vecs[3]  = mk(1, 0, 32'h1000, 4'hf, 6'd3,
                  ld(1, 1, 32'h1004, 4'b0100, 6'd5, 7'd9, 8'h21), none, 0);
    vecs[4]  = mk(1, 0, 32'h3000, 4'hf, 6'd30,
                  ld(2, 0, 32'h3000, 4'hf, 6'd33, 7'd40, 8'h44),
                  ld(1, 1, 32'h3001, 4'b0010, 6'd31, 7'd50, 8'h55), 2);
    vecs[5]  = mk(1, 0, 32'h4000, 4'hf, 6'd3,
                  ld(1, 0, 32'h4000, 4'hf, 6'd7, 7'd11, 8'h11),
                  ld(2, 1, 32'h4000, 4'hf, 6'd7, 7'd12, 8'h12), 2);
    vecs[6]  = mk(1, 0, 32'h5000, 4'hf, 6'd5,
                  ld(2, 0, 32'h5000, 4'b0001, 6'd5, 7'd13, 8'h13), none, 1);
    vecs[7]  = mk(1, 1, 32'h2000, 4'b1000, 6'd1,
                  ld(2, 1, 32'h2003, 4'b1000, 6'd10, 7'd20, 8'h7e), none, 1);
    vecs[8]  = mk(0, 0, 32'h1000, 4'hf, 6'd3,
                  ld(1, 1, 32'h1002, 4'b0100, 6'd5, 7'd9, 8'h21), none, 0);
    vecs[9]  = mk(1, 1, 32'h6000, 4'hf, 6'd34,
                  ld(2, 0, 32'h6000, 4'hf, 6'd30, 7'd59, 8'h59),
                  ld(1, 0, 32'h6000, 4'hf, 6'd35, 7'd60, 8'h66), 2);
    vecs[10] = mk(1, 0, 32'h1000, 4'hf, 6'd3,
                  ld(1, 1, 32'h8000_1000, 4'hf, 6'd5, 7'd9, 8'h21), none, 0);

    // Reset with random inputs: outputs must stay cleared.
    bus.redir_ready = 1'b1;
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      bus.st_en = SP'($urandom);  bus.st_addr = {$urandom, $urandom};
      bus.st_mask = 8'($urandom); bus.s1_en = LP'($urandom);  bus.s2_en = LP'($urandom);
      bus.s1_mask = 8'($urandom); bus.s2_mask = 8'($urandom);
      bus.lq_en = 1'b1;  bus.lq_robIdx = 7'($urandom);  bus.lq_fsq = 8'($urandom);
      @(negedge clk);
      chk("reset_valid", 64'(bus.redir_valid), 64'd0);
      chk("reset_rob", 64'(bus.redir_robIdx), 64'd0);
      chk("reset_fsq", 64'(bus.redir_fsq), 64'd0);
    end
    tick();
    clear_inputs();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_valid", 64'(bus.redir_valid), 64'd0);
      chk("idle_rob", 64'(bus.redir_robIdx), 64'd0);
    end

    // Table vectors through the scoreboard.
    mon_en = 1'b1;
    for (int k = 0; k < NV; k++) begin
      clear_inputs();
      if (vecs[k].st_v) put_store(int'(vecs[k].st_p), vecs[k].st_addr, vecs[k].st_mask,
                                  vecs[k].st_lq);
      put_load(vecs[k].la);
      put_load(vecs[k].lb);
      if (vecs[k].win == 2'd1) push_exp(3, vecs[k].la.rob, vecs[k].la.fsq);
      if (vecs[k].win == 2'd2) push_exp(3, vecs[k].lb.rob, vecs[k].lb.fsq);
      tick();
      clear_inputs();
      repeat (4) tick();
      chk($sformatf("vec%0d_drained", k), 64'(sb.size()), 64'd0);
      sb.delete();
    end

    // Two stores hit different loads; the older load wins across store pipelines.
    clear_inputs();
    put_store(0, 32'h7000, 4'hf, 6'd3);
    put_store(1, 32'h7100, 4'hf, 6'd2);
    put_load(ld(1, 0, 32'h7000, 4'hf, 6'd9, 7'd70, 8'h70));
    put_load(ld(2, 1, 32'h7100, 4'hf, 6'd6, 7'd71, 8'h71));
    push_exp(3, 7'd71, 8'h71);
    tick();
    clear_inputs();
    repeat (4) tick();
    chk("multi_store_drained", 64'(sb.size()), 64'd0);
    sb.delete();

    // lq report with the same lqIdx as R2 in the same cycle: lq payload wins.
    put_store(0, 32'h9000, 4'hf, 6'd3);
    put_load(ld(1, 0, 32'h9000, 4'hf, 6'd9, 7'd90, 8'h90));
    push_exp(3, 7'd91, 8'h91);
    tick();
    clear_inputs();
    tick();
    put_lq(6'd9, 7'd91, 8'h91);
    tick();
    clear_inputs();
    repeat (3) tick();
    chk("lq_tie_drained", 64'(sb.size()), 64'd0);
    sb.delete();

    // lq_en at t gives redirect at t+1.
    put_lq(6'd14, 7'd44, 8'h4e);
    push_exp(1, 7'd44, 8'h4e);
    tick();
    clear_inputs();
    repeat (2) tick();
    chk("lq_lat_drained", 64'(sb.size()), 64'd0);
    sb.delete();
    mon_en = 1'b0;

    // Backpressure: only older replaces; release drops valid.
    bus.redir_ready = 1'b0;
    put_lq(6'd8, 7'd80, 8'h80);
    tick();
    clear_inputs();
    chk("bp_load_valid", 64'(bus.redir_valid), 64'd1);
    chk("bp_load_rob", 64'(bus.redir_robIdx), 64'd80);
    put_lq(6'd4, 7'd40, 8'h40);
    tick();
    clear_inputs();
    chk("bp_older_rob", 64'(bus.redir_robIdx), 64'd40);
    chk("bp_older_fsq", 64'(bus.redir_fsq), 64'h40);
    put_lq(6'd12, 7'd120, 8'hc0);
    tick();
    clear_inputs();
    chk("bp_younger_valid", 64'(bus.redir_valid), 64'd1);
    chk("bp_younger_rob", 64'(bus.redir_robIdx), 64'd40);
    tick();
    chk("bp_hold_rob", 64'(bus.redir_robIdx), 64'd40);
    bus.redir_ready = 1'b1;
    tick();
    chk("bp_release_valid", 64'(bus.redir_valid), 64'd0);

    // Accept while a younger candidate arrives: it is loaded, then drains.
    bus.redir_ready = 1'b0;
    put_lq(6'd15, 7'd15, 8'h15);
    tick();
    clear_inputs();
    bus.redir_ready = 1'b1;
    put_lq(6'd20, 7'd22, 8'h22);
    tick();
    clear_inputs();
    chk("accept_reload_valid", 64'(bus.redir_valid), 64'd1);
    chk("accept_reload_rob", 64'(bus.redir_robIdx), 64'd22);
    tick();
    chk("accept_drain_valid", 64'(bus.redir_valid), 64'd0);

    // Flush one cycle after a hit squashes it in flight.
    put_store(0, 32'h1000, 4'hf, 6'd3);
    put_load(ld(1, 1, 32'h1002, 4'b0100, 6'd5, 7'd9, 8'h21));
    tick();
    clear_inputs();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("flush_inflight_%0d", k), 64'(bus.redir_valid), 64'd0);
      tick();
    end

    // Flush with a pending redirect; a same-cycle candidate is dropped.
    bus.redir_ready = 1'b0;
    put_lq(6'd8, 7'd80, 8'h80);
    tick();
    clear_inputs();
    chk("flush_pend_before", 64'(bus.redir_valid), 64'd1);
    bus.flush = 1'b1;
    put_lq(6'd2, 7'd2, 8'h02);
    tick();
    clear_inputs();
    chk("flush_pend_after", 64'(bus.redir_valid), 64'd0);
    tick();
    chk("flush_pend_stays", 64'(bus.redir_valid), 64'd0);

    // Asynchronous reset mid-stream, then the first cycle after release is processed.
    put_lq(6'd8, 7'd80, 8'h80);
    tick();
    clear_inputs();
    rst = 1'b0;
    #1;
    chk("async_reset_valid", 64'(bus.redir_valid), 64'd0);
    chk("async_reset_rob", 64'(bus.redir_robIdx), 64'd0);
    tick();
    rst = 1'b1;
    put_lq(6'd3, 7'd5, 8'h55);
    tick();
    clear_inputs();
    chk("post_reset_valid", 64'(bus.redir_valid), 64'd1);
    chk("post_reset_rob", 64'(bus.redir_robIdx), 64'd5);
    bus.redir_ready = 1'b1;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
